// File: rtl/alu_result_buf.sv
// Two-entry in-order result buffer between the ALU and register writeback; flags are captured at push.
// Optional per-entry parity and the out_parity port are enabled by defining ALU_RES_PARITY_EN.
module alu_result_buf #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DEST_W-1:0] in_dest,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [DEST_W-1:0] out_dest,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_lbz,
`ifdef ALU_RES_PARITY_EN
    output logic              out_parity,
`endif
    output logic [1:0]        level,
    output logic [15:0]       ret_cnt
);

    logic [DATA_W-1:0] data_q [2];
    logic [DATA_W-1:0] data_d [2];
    logic [DEST_W-1:0] dest_q [2];
    logic [DEST_W-1:0] dest_d [2];
    logic [1:0]        zero_q, zero_d;
    logic [1:0]        neg_q, neg_d;
    logic [1:0]        lbz_q, lbz_d;
`ifdef ALU_RES_PARITY_EN
    logic [1:0]        parity_q, parity_d;
`endif

    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  level_q, level_d;
    logic [15:0] ret_cnt_q, ret_cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        push, pop;

    assign out_valid = (level_q != 2'd0);
    assign in_ready  = in_ready_q;
    assign level     = level_q;
    assign ret_cnt   = ret_cnt_q;

    // in_ready is registered from the next level, so out_ready never reaches it combinationally
    always_comb begin
        push       = in_valid & in_ready_q & ~flush;
        pop        = out_valid & out_ready & ~flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        ret_cnt_d  = ret_cnt_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            level_d  = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d  = ~rd_ptr_q;
                ret_cnt_d = ret_cnt_q + 16'd1;
            end
            level_d = level_q + {1'b0, push} - {1'b0, pop};
        end
        in_ready_d = (level_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            level_q    <= 2'd0;
            ret_cnt_q  <= 16'd0;
            in_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ret_cnt_q  <= ret_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Entry payload is never cleared; only level/pointers decide what is live
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            data_d[i] = data_q[i];
            dest_d[i] = dest_q[i];
        end
        zero_d = zero_q;
        neg_d  = neg_q;
        lbz_d  = lbz_q;
`ifdef ALU_RES_PARITY_EN
        parity_d = parity_q;
`endif
        if (push) begin
            data_d[wr_ptr_q] = in_data;
            dest_d[wr_ptr_q] = in_dest;
            zero_d[wr_ptr_q] = (in_data == '0);
            neg_d[wr_ptr_q]  = in_data[DATA_W-1];
            lbz_d[wr_ptr_q]  = (in_data[7:0] == 8'd0);
`ifdef ALU_RES_PARITY_EN
            parity_d[wr_ptr_q] = ^in_data[7:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            data_q[i] <= data_d[i];
            dest_q[i] <= dest_d[i];
        end
        zero_q <= zero_d;
        neg_q  <= neg_d;
        lbz_q  <= lbz_d;
`ifdef ALU_RES_PARITY_EN
        parity_q <= parity_d;
`endif
    end

    always_comb begin
        out_data = '0;
        out_dest = '0;
        out_zero = 1'b0;
        out_neg  = 1'b0;
        out_lbz  = 1'b0;
`ifdef ALU_RES_PARITY_EN
        out_parity = 1'b0;
`endif
        if (out_valid) begin
            out_data = data_q[rd_ptr_q];
            out_dest = dest_q[rd_ptr_q];
            out_zero = zero_q[rd_ptr_q];
            out_neg  = neg_q[rd_ptr_q];
            out_lbz  = lbz_q[rd_ptr_q];
`ifdef ALU_RES_PARITY_EN
            out_parity = parity_q[rd_ptr_q];
`endif
        end
    end

endmodule

// File: tb/tb_alu_result_buf.sv
// Scoreboard bench for alu_result_buf: a queue model tracks expected entries, level, in_ready and ret_cnt.
module tb_alu_result_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_dest;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_dest;
    logic        out_zero;
    logic        out_neg;
    logic        out_lbz;
    logic        out_parity;
    logic [1:0]  level;
    logic [15:0] ret_cnt;

    alu_result_buf #(.DATA_W(32), .DEST_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_dest  (out_dest),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_lbz   (out_lbz),
`ifdef ALU_RES_PARITY_EN
        .out_parity(out_parity),
`endif
        .level     (level),
        .ret_cnt   (ret_cnt)
    );

`ifndef ALU_RES_PARITY_EN
    assign out_parity = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  dest;
        logic        zero;
        logic        neg;
        logic        lbz;
        logic        par;
    } entry_t;

    entry_t      sb[$];
    logic        m_in_ready;
    logic [15:0] m_ret;
    int          n_vec;
    int          n_miss;

    wire [40:0] obs_head = {out_valid, out_data, out_dest, out_zero, out_neg, out_lbz, out_parity};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic entry_t make_entry(input logic [31:0] d, input logic [3:0] t);
        entry_t e;
        e.data = d;
        e.dest = t;
        e.zero = (d == 32'd0);
        e.neg  = d[31];
        e.lbz  = (d[7:0] == 8'd0);
`ifdef ALU_RES_PARITY_EN
        e.par  = ^d[7:0];
`else
        e.par  = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [40:0] head_exp();
        if (sb.size() == 0) return 41'd0;
        return {1'b1, sb[0]};
    endfunction

    // Advance one clock and update the model with the handshakes the inputs imply
    task automatic tick();
        logic push, pop;
        push = in_valid && m_in_ready && !flush;
        pop  = (sb.size() != 0) && out_ready && !flush;
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            m_ret      = 16'd0;
            m_in_ready = 1'b0;
        end else if (flush) begin
            sb.delete();
            m_in_ready = 1'b1;
        end else begin
            if (pop) begin
                void'(sb.pop_front());
                m_ret = m_ret + 16'd1;
            end
            if (push) sb.push_back(make_entry(in_data, in_dest));
            m_in_ready = (sb.size() != 2);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({in_ready, level, out_valid} !== 4'b0) begin
                n_miss++;
                $display("[TB] FAIL reset_hold: got ready/level/valid %b/%0d/%b expected 0/0/0", in_ready, level, out_valid);
            end
        end
        rst_n = 1'b1;
        tick();
        n_vec++;
        if (in_ready !== 1'b1 || level !== 2'd0 || ret_cnt !== 16'd0) begin
            n_miss++;
            $display("[TB] FAIL reset_release: got ready %b level %0d ret %h expected 1 0 0000", in_ready, level, ret_cnt);
        end
    endtask

    task automatic test_single_pass();
        in_valid = 1'b1; in_data = 32'h0000_0080; in_dest = 4'd3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (obs_head !== head_exp()) begin
            n_miss++;
            $display("[TB] FAIL single_head: got %h expected %h", obs_head, head_exp());
        end
        n_vec++;
        if ({out_valid, out_data, out_dest, out_zero, out_neg, out_lbz} !== {1'b1, 32'h80, 4'd3, 3'b000}) begin
            n_miss++;
            $display("[TB] FAIL single_fields: got v%b d%h t%0d z%b n%b l%b", out_valid, out_data, out_dest, out_zero, out_neg, out_lbz);
        end
`ifdef ALU_RES_PARITY_EN
        n_vec++;
        if (out_parity !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL single_parity: got %b expected 1", out_parity);
        end
`endif
        tick();
        n_vec++;
        if (ret_cnt !== 16'd1 || level !== 2'd0 || ret_cnt !== m_ret) begin
            n_miss++;
            $display("[TB] FAIL single_retire: got ret %h level %0d expected 0001 0", ret_cnt, level);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hFFFF_FF00; in_dest = 4'd1;
        tick();
        in_data = 32'h0000_0000; in_dest = 4'd2;
        tick();
        n_vec++;
        if (level !== 2'd2 || in_ready !== 1'b0 || in_ready !== m_in_ready) begin
            n_miss++;
            $display("[TB] FAIL fill_full: got level %0d ready %b expected 2 0", level, in_ready);
        end
        in_data = 32'h1234_5678; in_dest = 4'd5;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (level !== 2'(sb.size()) || obs_head !== head_exp()) begin
            n_miss++;
            $display("[TB] FAIL fill_ignore: got level %0d head %h expected %0d %h", level, obs_head, sb.size(), head_exp());
        end
        n_vec++;
        if (out_data !== 32'hFFFF_FF00 || out_neg !== 1'b1 || out_lbz !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL fill_head_flags: got d%h n%b l%b expected ffffff00 1 1", out_data, out_neg, out_lbz);
        end
        out_ready = 1'b1;
        tick();
        n_vec++;
        if (obs_head !== head_exp() || out_zero !== 1'b1 || out_dest !== 4'd2) begin
            n_miss++;
            $display("[TB] FAIL drain_second: got %h expected %h", obs_head, head_exp());
        end
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL drain_ready: got %b expected 1", in_ready);
        end
        tick();
        n_vec++;
        if (level !== 2'd0 || out_valid !== 1'b0 || ret_cnt !== m_ret) begin
            n_miss++;
            $display("[TB] FAIL drain_empty: got level %0d valid %b ret %h expected 0 0 %h", level, out_valid, ret_cnt, m_ret);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] prev;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 32'd1; in_dest = 4'd1;
        tick();
        for (int i = 2; i <= 10; i++) begin
            prev = ret_cnt;
            in_data = 32'(i); in_dest = 4'(i);
            tick();
            n_vec++;
            if (level !== 2'd1 || obs_head !== head_exp() || out_data !== 32'(i)) begin
                n_miss++;
                $display("[TB] FAIL b2b_head: cycle %0d got level %0d head %h expected 1 %h", i, level, obs_head, head_exp());
            end
            n_vec++;
            if (ret_cnt !== prev + 16'd1 || ret_cnt !== m_ret) begin
                n_miss++;
                $display("[TB] FAIL b2b_ret: cycle %0d got %h expected %h", i, ret_cnt, m_ret);
            end
        end
        in_valid = 1'b0;
        tick();
        n_vec++;
        if (level !== 2'd0 || ret_cnt !== m_ret) begin
            n_miss++;
            $display("[TB] FAIL b2b_drain: got level %0d ret %h expected 0 %h", level, ret_cnt, m_ret);
        end
    endtask

    task automatic test_flush();
        logic [15:0] saved;
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = 32'hA5A5_0000 + 32'(i); in_dest = 4'(7 + i);
            tick();
        end
        n_vec++;
        if (level !== 2'd2) begin
            n_miss++;
            $display("[TB] FAIL flush_prefill: got level %0d expected 2", level);
        end
        saved = ret_cnt;
        flush = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (level !== 2'd0 || obs_head !== 41'd0 || ret_cnt !== saved || in_ready !== 1'b1) begin
            n_miss++;
            $display("[TB] FAIL flush_result: got level %0d head %h ret %h ready %b expected 0 0 %h 1", level, obs_head, ret_cnt, saved, in_ready);
        end
        in_valid = 1'b1; in_data = 32'h0000_0101; in_dest = 4'd4;
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (obs_head !== head_exp()) begin
            n_miss++;
            $display("[TB] FAIL flush_recover: got %h expected %h", obs_head, head_exp());
        end
        tick();
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0042; in_dest = 4'd6;
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        n_vec++;
        if (level !== 2'd0 || out_valid !== 1'b0 || ret_cnt !== 16'd0 || in_ready !== 1'b0) begin
            n_miss++;
            $display("[TB] FAIL mid_reset: got level %0d valid %b ret %h ready %b expected 0 0 0000 0", level, out_valid, ret_cnt, in_ready);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ret_wrap();
        out_ready = 1'b1;
        in_valid = 1'b1; in_dest = 4'd0; in_data = 32'd0;
        tick();
        for (int i = 0; i < 65535; i++) begin
            in_data = $urandom;
            tick();
        end
        n_vec++;
        if (ret_cnt !== 16'hFFFF || ret_cnt !== m_ret) begin
            n_miss++;
            $display("[TB] FAIL wrap_preload: got %h expected ffff", ret_cnt);
        end
        n_vec++;
        if (level !== 2'd1 || obs_head !== head_exp()) begin
            n_miss++;
            $display("[TB] FAIL wrap_stream: got level %0d head %h expected 1 %h", level, obs_head, head_exp());
        end
        in_data = $urandom;
        tick();
        n_vec++;
        if (ret_cnt !== 16'h0000) begin
            n_miss++;
            $display("[TB] FAIL wrap_roll: got %h expected 0000", ret_cnt);
        end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        m_in_ready = 1'b0; m_ret = 16'd0;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 32'd0; in_dest = 4'd0;
        test_reset();
        test_single_pass();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        test_ret_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_result_buf.md
# alu_result_buf

Two-entry result buffer directly downstream of the rotate/ALU datapath. It captures each 32-bit ALU result with its destination register tag and computes status flags at capture. It then presents results in order to register-file writeback over a valid/ready handshake. The buffer decouples ALU issue from writeback stalls without a combinational path from `out_ready` to `in_ready`.

## Interface
- `DATA_W`, 32, result width
- `DEST_W`, 4, destination register tag width
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `flush`  in  1  synchronous discard of all buffered entries
- `in_valid`  in  1  ALU result valid
- `in_ready`  out  1  buffer can accept; registered
- `in_data`  in  DATA_W  ALU result
- `in_dest`  in  DEST_W  destination register tag
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  writeback accepts head
- `out_data`  out  DATA_W  head result
- `out_dest`  out  DEST_W  head tag
- `out_zero`  out  1  head result == 0
- `out_neg`  out  1  head result bit DATA_W-1
- `out_lbz`  out  1  head result bits [7:0] == 0
- `level`  out  2  occupancy, 0..2
- `ret_cnt`  out  16  count of popped entries, wraps
- `out_parity`  out  1  only with `ALU_RES_PARITY_EN`: XOR of head bits [7:0]

## Operation
- Storage is 2 entries, circular. Each entry holds data, dest, zero, neg, lbz and, if enabled, parity. Flags are computed from `in_data` at push and stored, not recomputed at the output.
- A push occurs when `in_valid & in_ready & !flush`. A pop occurs when `out_valid & out_ready & !flush`.
- The write pointer advances on push and the read pointer advances on pop. Both are 1 bit and wrap 1->0.
- `level_next = level + push - pop`.
- `out_valid = (level != 0)`. The `out_*` fields come from the head entry and hold stable while `out_valid & !out_ready`.
- Simultaneous push and pop at level 1: level stays 1 and the new entry becomes the head next cycle.
- Simultaneous push and pop at level 2 cannot happen, because `in_ready` is 0.
- Pop at level 0 has no effect. A push with `in_valid` high while `in_ready` is low is ignored; the upstream stage holds its data.
- `flush` has priority. Next cycle `level` = 0 and both pointers = 0. Any handshake in the flush cycle is dropped and `ret_cnt` is unchanged.
- `ret_cnt` increments by 1 per pop and wraps 0xFFFF -> 0x0000. Flush does not clear it.
- Stored data is not cleared on flush or pop. Only the valid and level state matters.

## Timing
- Reset, sampled at the `clk` edge with `rst_n` = 0: `level` = 0, pointers = 0, `ret_cnt` = 0, `in_ready` = 0, and `out_valid` = 0.
- While `out_valid` is 0, `out_data`, `out_dest` and all flags read 0.
- `in_ready` is a register equal to `(level_next != 2)`. It is therefore 0 during reset and becomes 1 on the first edge after `rst_n` rises.
- Latency: a push at edge k gives `out_valid` = 1 with that data after edge k. This is 1 cycle. There is no same-cycle bypass.
- When full, a pop at edge k raises `in_ready` after edge k. A push cannot occur in the same cycle as the pop that frees space.
- Reset asserted mid-stream discards all entries, exactly like flush, and also clears `ret_cnt`.
- No combinational path exists from `out_ready` or `in_valid` to any output.

## Configuration
- `ALU_RES_PARITY_EN` defined: each entry stores a parity bit (XOR of `in_data[7:0]`) and the `out_parity` port exists. `out_parity` reads 0 when `out_valid` = 0 and 0 on reset.
- `ALU_RES_PARITY_EN` undefined: the `out_parity` port and its storage are absent. All other behaviour is identical.

## Test plan
- Reset/ready: hold `rst_n` = 0 for 3 cycles, then release. Required: `in_ready` = 0 during reset and = 1 one edge after release, `level` = 0, `ret_cnt` = 0.
- Single pass: push data 0x0000_0080 with dest 3 while `out_ready` = 1. Required next cycle: `out_valid` = 1, `out_data` = 0x80, `out_dest` = 3, `out_zero` = 0, `out_neg` = 0, `out_lbz` = 0, parity = 1. One cycle later: `ret_cnt` = 1, `level` = 0.
- Fill/backpressure: with `out_ready` = 0, push 0xFFFF_FF00 (dest 1), then 0x0000_0000 (dest 2). Required: `level` = 2 and `in_ready` = 0. A third `in_valid` is ignored. The head stays 0xFFFF_FF00 with `neg` = 1 and `lbz` = 1. Raising `out_ready` pops both in order; the second entry has `zero` = 1.
- Concurrent push/pop at level 1 for 10 cycles with incrementing data 1..10. Required: `level` stays 1, outputs appear in order 1..10 with 1-cycle lag, and `ret_cnt` increments each cycle.
- Flush: at level 2, assert `flush` together with `in_valid` and `out_ready`. Required: next cycle `level` = 0, `out_valid` = 0, `ret_cnt` unchanged, and `in_ready` = 1.
- Counter wrap: preload by popping 65535 entries, then pop 1 more. Required: `ret_cnt` goes 0xFFFF -> 0x0000.
